gcbp_subimage_addr_gen: RTL and testbench
=========================================

# gcbp_subimage_addr_gen

Upstream address generator for the GCBP subimage BRAM array. It consumes a raster pixel stream, tracks the pixel position within the frame, and splits the frame into a 4x4 grid of equal subimages. Per accepted pixel it produces the subimage coordinates (vertical, horizontal, each 0-3), the in-subimage BRAM address, and the pixel data with a write strobe. Its outputs feed the one-hot BRAM write-enable decoder and the 16 BRAM write ports directly.

## Interface
- IMG_W, 640, frame width in pixels; must be divisible by 4
- IMG_H, 480, frame height in lines; must be divisible by 4
- DATA_W, 1, pixel data width (GCBP bit)
- SUB_W, IMG_W/4, derived localparam: subimage width
- SUB_H, IMG_H/4, derived localparam: subimage height
- ADDR_W, clog2(SUB_W*SUB_H), derived localparam; 15 at defaults

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  pixel present this cycle
- pix_sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0)
- pix_data  in  DATA_W  pixel value
- vert_subimage_cnt  out  2  subimage row of the written pixel (0-3)
- hori_subimage_cnt  out  2  subimage column of the written pixel (0-3)
- bram_addr  out  ADDR_W  address inside the subimage: sub_y*SUB_W + sub_x
- bram_din  out  DATA_W  registered pix_data
- bram_we  out  1  write strobe; qualifies all outputs above
- frame_done  out  1  one-cycle pulse with the write of pixel (IMG_W-1, IMG_H-1)
- sync_err  out  1  one-cycle pulse when pix_sof arrives mid-frame

## Operation
- States: WAIT_SOF (reset state) and ACTIVE.
- WAIT_SOF: pix_valid without pix_sof is dropped, with no write. pix_valid & pix_sof writes pixel (0,0) and moves to ACTIVE.
- ACTIVE: each pix_valid writes one pixel. Pixels without pix_valid are ignored, and the counters hold.
- Counters: sub_x (0..SUB_W-1) with hori_subimage_cnt, and sub_y (0..SUB_H-1) with vert_subimage_cnt.
  - sub_x wrap increments hori. Hori wrap from 3 to 0 marks the end of the line.
  - End of line increments sub_y. sub_y wrap increments vert.
- Address uses no multiplier:
  - addr increments per pixel.
  - On sub_x wrap, addr reloads row_base.
  - On end of line, row_base += SUB_W, or row_base = 0 if sub_y wraps. addr then loads the new row_base.
- Last pixel (hori=3, vert=3, sub_x=SUB_W-1, sub_y=SUB_H-1): write it, pulse frame_done, clear all counters, and return to WAIT_SOF.
- pix_valid & pix_sof in ACTIVE (mid-frame):
  - Pulse sync_err.
  - Treat the pixel as (0,0) of a new frame: counters restart, write it at addr 0, subimage (0,0).
  - Stay in ACTIVE. frame_done is not pulsed.
- pix_sof on the final pixel of a frame counts as mid-frame: sync_err is pulsed, that pixel becomes (0,0), and frame_done is not pulsed.
- All additions are unsigned. row_base and addr are ADDR_W wide and never exceed SUB_W*SUB_H-1.

## Timing
- Latency is 1 cycle. A pixel accepted at edge N appears on the outputs with bram_we=1 after edge N.
- bram_we is high only in the cycle following an accepted pixel. Otherwise it is 0.
- When bram_we=0, the remaining data/address outputs hold their last values.
- Full throughput: one pixel per cycle, back-to-back, with no stall path and no backpressure.
- frame_done and sync_err are registered and aligned with the bram_we of the causing pixel.
- Reset values: state=WAIT_SOF; all counters 0; vert/hori_subimage_cnt=0, bram_addr=0, bram_din=0, bram_we=0, frame_done=0, sync_err=0.
- Reset asserted mid-frame aborts the frame immediately, with no further writes. After release, the block waits for pix_sof.

## Test plan
Bench parameters: IMG_W=8, IMG_H=8, so SUB_W=2, SUB_H=2, ADDR_W=2.
1. Reset, then feed 64 valid pixels with sof on the first. Required response:
   - pixel (0,0): v=0, h=0, addr=0
   - (2,0): h=1, addr=0
   - (1,1): h=0, v=0, addr=3
   - (4,3): v=1, h=2, addr=2
   - (7,7): v=3, h=3, addr=3, with frame_done=1 in the same cycle
   - 64 bram_we pulses in total
2. Feed 5 valid pixels without sof after reset, then a full frame with sof. Required: no bram_we for the first 5; the frame behaves exactly as in scenario 1.
3. Feed frame pixels with pix_valid toggling 1/0 each cycle. Required: the addr/cnt sequence matches scenario 1, and bram_we appears only after valid cycles.
4. Assert sof on pixel 20 of a frame. Required: sync_err=1 with that write, which has v=0, h=0, addr=0. A further 63 pixels then produce frame_done on the last one.
5. Assert rst_n low for 1 cycle during pixel 30. Required: all outputs are 0 immediately. A subsequent frame without sof writes nothing; a frame with sof restarts at addr 0.
6. Run two frames back-to-back, with the sof of frame 2 in the cycle after the last pixel of frame 1. Required: frame_done once per frame, no sync_err, and frame 2 starts at v=0, h=0, addr=0.

Source files
------------

// File: rtl/gcbp_subimage_addr_gen_if.sv
// Pixel-stream input and subimage BRAM write bundle for gcbp_subimage_addr_gen.
// master drives pixels and observes the BRAM writes; slave is the address generator.
interface gcbp_subimage_addr_gen_if #(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 15
);
  logic              pix_valid;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_data;
  logic [1:0]        vert_subimage_cnt;
  logic [1:0]        hori_subimage_cnt;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic              frame_done;
  logic              sync_err;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  vert_subimage_cnt, hori_subimage_cnt, bram_addr, bram_din,
    input  bram_we, frame_done, sync_err
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output vert_subimage_cnt, hori_subimage_cnt, bram_addr, bram_din,
    output bram_we, frame_done, sync_err
  );
endinterface

// File: rtl/gcbp_subimage_addr_gen.sv
// Splits a raster pixel stream into a 4x4 subimage grid and generates per-pixel
// BRAM write coordinates/address with one cycle of latency and no multiplier.
//
// state    | meaning
// WAIT_SOF | idle; pixels without pix_sof are dropped
// ACTIVE   | inside a frame; every valid pixel is written
module gcbp_subimage_addr_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  gcbp_subimage_addr_gen_if.slave  bus
);
  localparam int SUB_W  = IMG_W / 4;
  localparam int SUB_H  = IMG_H / 4;
  localparam int ADDR_W = $clog2(SUB_W * SUB_H);
  localparam int XW     = (SUB_W > 1) ? $clog2(SUB_W) : 1;
  localparam int YW     = (SUB_H > 1) ? $clog2(SUB_H) : 1;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t              r_state, w_state_nxt;
  logic [XW-1:0]       r_sub_x, w_cur_x, w_x_nxt;
  logic [YW-1:0]       r_sub_y, w_cur_y, w_y_nxt;
  logic [1:0]          r_hori, w_cur_h, w_h_nxt;
  logic [1:0]          r_vert, w_cur_v, w_v_nxt;
  logic [ADDR_W-1:0]   r_addr, w_cur_addr, w_addr_nxt;
  logic [ADDR_W-1:0]   r_row_base, w_cur_row, w_row_nxt;

  logic [1:0]          r_vert_o, r_hori_o;
  logic [ADDR_W-1:0]   r_bram_addr;
  logic [DATA_W-1:0]   r_bram_din;
  logic                r_bram_we, r_frame_done, r_sync_err;

  logic w_accept, w_restart, w_sync_err, w_frame_done;
  logic w_x_wrap, w_y_wrap, w_eol, w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_SOF;
      r_sub_x      <= '0;
      r_sub_y      <= '0;
      r_hori       <= '0;
      r_vert       <= '0;
      r_addr       <= '0;
      r_row_base   <= '0;
      r_vert_o     <= '0;
      r_hori_o     <= '0;
      r_bram_addr  <= '0;
      r_bram_din   <= '0;
      r_bram_we    <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sub_x      <= w_x_nxt;
      r_sub_y      <= w_y_nxt;
      r_hori       <= w_h_nxt;
      r_vert       <= w_v_nxt;
      r_addr       <= w_addr_nxt;
      r_row_base   <= w_row_nxt;
      r_bram_we    <= w_accept;
      r_frame_done <= w_frame_done;
      r_sync_err   <= w_sync_err;
      if (w_accept) begin
        r_vert_o    <= w_cur_v;
        r_hori_o    <= w_cur_h;
        r_bram_addr <= w_cur_addr;
        r_bram_din  <= bus.pix_data;
      end
    end
  end

  // Counters hold the position of the next pixel; a sof pixel is forced to (0,0).
  always_comb begin
    w_accept     = bus.pix_valid & (bus.pix_sof | (r_state == ACTIVE));
    w_restart    = bus.pix_valid & bus.pix_sof;
    w_sync_err   = w_restart & (r_state == ACTIVE);
    w_cur_x      = w_restart ? '0 : r_sub_x;
    w_cur_y      = w_restart ? '0 : r_sub_y;
    w_cur_h      = w_restart ? '0 : r_hori;
    w_cur_v      = w_restart ? '0 : r_vert;
    w_cur_addr   = w_restart ? '0 : r_addr;
    w_cur_row    = w_restart ? '0 : r_row_base;
    w_x_wrap     = (w_cur_x == XW'(SUB_W - 1));
    w_y_wrap     = (w_cur_y == YW'(SUB_H - 1));
    w_eol        = w_x_wrap & (w_cur_h == 2'd3);
    w_last       = w_eol & w_y_wrap & (w_cur_v == 2'd3);

    w_state_nxt  = r_state;
    w_x_nxt      = r_sub_x;
    w_y_nxt      = r_sub_y;
    w_h_nxt      = r_hori;
    w_v_nxt      = r_vert;
    w_addr_nxt   = r_addr;
    w_row_nxt    = r_row_base;
    w_frame_done = 1'b0;

    if (w_accept) begin
      w_state_nxt = ACTIVE;
      w_x_nxt     = w_cur_x + XW'(1);
      w_y_nxt     = w_cur_y;
      w_h_nxt     = w_cur_h;
      w_v_nxt     = w_cur_v;
      w_addr_nxt  = w_cur_addr + ADDR_W'(1);
      w_row_nxt   = w_cur_row;
      if (w_last) begin
        w_state_nxt  = WAIT_SOF;
        w_frame_done = 1'b1;
        w_x_nxt      = '0;
        w_y_nxt      = '0;
        w_h_nxt      = '0;
        w_v_nxt      = '0;
        w_addr_nxt   = '0;
        w_row_nxt    = '0;
      end else if (w_x_wrap) begin
        w_x_nxt    = '0;
        w_h_nxt    = w_cur_h + 2'd1;
        w_addr_nxt = w_cur_row;
        if (w_eol) begin
          if (w_y_wrap) begin
            w_y_nxt   = '0;
            w_v_nxt   = w_cur_v + 2'd1;
            w_row_nxt = '0;
          end else begin
            w_y_nxt   = w_cur_y + YW'(1);
            w_row_nxt = w_cur_row + ADDR_W'(SUB_W);
          end
          w_addr_nxt = w_row_nxt;
        end
      end
    end
  end

  assign bus.vert_subimage_cnt = r_vert_o;
  assign bus.hori_subimage_cnt = r_hori_o;
  assign bus.bram_addr         = r_bram_addr;
  assign bus.bram_din          = r_bram_din;
  assign bus.bram_we           = r_bram_we;
  assign bus.frame_done        = r_frame_done;
  assign bus.sync_err          = r_sync_err;
endmodule

// File: tb/tb_gcbp_subimage_addr_gen.sv
// Directed bench for gcbp_subimage_addr_gen on an 8x8 frame (2x2 subimages).
module tb_gcbp_subimage_addr_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  gcbp_subimage_addr_gen_if #(.DATA_W(1), .ADDR_W(2)) bus ();

  gcbp_subimage_addr_gen #(.IMG_W(8), .IMG_H(8), .DATA_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected {vert, hori, addr} of raster pixel p in an 8x8 frame.
  function automatic logic [5:0] ex_pos(input int p);
    int x, y;
    x = p % 8;
    y = p / 8;
    return {2'(y / 2), 2'(x / 2), 2'((y % 2) * 2 + (x % 2))};
  endfunction

  function automatic logic ex_d(input int p);
    return p[0] ^ p[2];
  endfunction

  function automatic logic [5:0] got_pos();
    return {bus.vert_subimage_cnt, bus.hori_subimage_cnt, bus.bram_addr};
  endfunction

  task automatic step(input logic v, input logic s, input logic d);
    @(negedge clk);
    bus.pix_valid = v;
    bus.pix_sof   = s;
    bus.pix_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.bram_we); end
    total++; if (got_pos() !== 6'h00) begin bad++; $display("FAIL reset_pos got=%h want=00", got_pos()); end
    total++; if (bus.bram_din !== 1'b0) begin bad++; $display("FAIL reset_din got=%b want=0", bus.bram_din); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", bus.frame_done); end
    total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL reset_se got=%b want=0", bus.sync_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    int we_cnt = 0;
    logic [5:0] spot;
    for (int p = 0; p < 64; p++) begin
      step(1'b1, p == 0, ex_d(p));
      if (bus.bram_we === 1'b1) we_cnt++;
      total++; if (bus.bram_we !== 1'b1) begin bad++; $display("FAIL ff_we p=%0d got=%b want=1", p, bus.bram_we); end
      total++; if (got_pos() !== ex_pos(p)) begin bad++; $display("FAIL ff_pos p=%0d got=%h want=%h", p, got_pos(), ex_pos(p)); end
      total++; if (bus.bram_din !== ex_d(p)) begin bad++; $display("FAIL ff_din p=%0d got=%b want=%b", p, bus.bram_din, ex_d(p)); end
      total++; if (bus.frame_done !== (p == 63)) begin bad++; $display("FAIL ff_fd p=%0d got=%b", p, bus.frame_done); end
      total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL ff_se p=%0d got=%b want=0", p, bus.sync_err); end
      if (p == 0 || p == 2 || p == 9 || p == 28 || p == 63) begin
        case (p)
          0:       spot = {2'd0, 2'd0, 2'd0};
          2:       spot = {2'd0, 2'd1, 2'd0};
          9:       spot = {2'd0, 2'd0, 2'd3};
          28:      spot = {2'd1, 2'd2, 2'd2};
          default: spot = {2'd3, 2'd3, 2'd3};
        endcase
        total++; if (got_pos() !== spot) begin bad++; $display("FAIL ff_spot p=%0d got=%h want=%h", p, got_pos(), spot); end
      end
    end
    total++; if (we_cnt != 64) begin bad++; $display("FAIL ff_we_count got=%0d want=64", we_cnt); end
    step(1'b0, 1'b0, 1'b0);
    total++; if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL ff_idle_we got=%b want=0", bus.bram_we); end
    total++; if (got_pos() !== 6'h3F) begin bad++; $display("FAIL ff_hold got=%h want=3f", got_pos()); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL ff_fd_pulse got=%b want=0", bus.frame_done); end
    step(1'b1, 1'b0, 1'b1);
    total++; if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL ff_after_done_we got=%b want=0", bus.bram_we); end
  endtask

  task automatic test_no_sof();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      total++; if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL nosof_we i=%0d got=%b want=0", i, bus.bram_we); end
    end
    for (int p = 0; p < 64; p++) begin
      step(1'b1, p == 0, ex_d(p));
      total++; if (bus.bram_we !== 1'b1) begin bad++; $display("FAIL nosof_fr_we p=%0d got=%b want=1", p, bus.bram_we); end
      total++; if (got_pos() !== ex_pos(p)) begin bad++; $display("FAIL nosof_pos p=%0d got=%h want=%h", p, got_pos(), ex_pos(p)); end
      total++; if (bus.frame_done !== (p == 63)) begin bad++; $display("FAIL nosof_fd p=%0d got=%b", p, bus.frame_done); end
    end
  endtask

  task automatic test_gapped();
    int p;
    logic v;
    for (int i = 0; i < 128; i++) begin
      v = (i % 2 == 0);
      p = i / 2;
      step(v, i == 0, ex_d(p));
      total++; if (bus.bram_we !== v) begin bad++; $display("FAIL gap_we i=%0d got=%b want=%b", i, bus.bram_we, v); end
      total++; if (got_pos() !== ex_pos(p)) begin bad++; $display("FAIL gap_pos i=%0d got=%h want=%h", i, got_pos(), ex_pos(p)); end
      total++; if (bus.frame_done !== (v && p == 63)) begin bad++; $display("FAIL gap_fd i=%0d got=%b", i, bus.frame_done); end
    end
  endtask

  task automatic test_mid_sof();
    for (int p = 0; p < 20; p++) step(1'b1, p == 0, ex_d(p));
    step(1'b1, 1'b1, 1'b1);
    total++; if (bus.sync_err !== 1'b1) begin bad++; $display("FAIL mid_se got=%b want=1", bus.sync_err); end
    total++; if (bus.bram_we !== 1'b1) begin bad++; $display("FAIL mid_we got=%b want=1", bus.bram_we); end
    total++; if (got_pos() !== 6'h00) begin bad++; $display("FAIL mid_pos got=%h want=00", got_pos()); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL mid_fd got=%b want=0", bus.frame_done); end
    for (int p = 1; p < 64; p++) begin
      step(1'b1, 1'b0, ex_d(p));
      total++; if (got_pos() !== ex_pos(p)) begin bad++; $display("FAIL mid_pos p=%0d got=%h want=%h", p, got_pos(), ex_pos(p)); end
      total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL mid_se2 p=%0d got=%b want=0", p, bus.sync_err); end
      total++; if (bus.frame_done !== (p == 63)) begin bad++; $display("FAIL mid_fd2 p=%0d got=%b", p, bus.frame_done); end
    end
  endtask

  task automatic test_sof_on_last();
    for (int p = 0; p < 63; p++) step(1'b1, p == 0, ex_d(p));
    step(1'b1, 1'b1, 1'b0);
    total++; if (bus.sync_err !== 1'b1) begin bad++; $display("FAIL last_se got=%b want=1", bus.sync_err); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL last_fd got=%b want=0", bus.frame_done); end
    total++; if (got_pos() !== 6'h00) begin bad++; $display("FAIL last_pos got=%h want=00", got_pos()); end
    step(1'b1, 1'b0, ex_d(1));
    total++; if (bus.bram_we !== 1'b1) begin bad++; $display("FAIL last_next_we got=%b want=1", bus.bram_we); end
    total++; if (got_pos() !== ex_pos(1)) begin bad++; $display("FAIL last_next_pos got=%h want=%h", got_pos(), ex_pos(1)); end
    for (int p = 2; p < 64; p++) step(1'b1, 1'b0, ex_d(p));
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL last_end_fd got=%b want=1", bus.frame_done); end
  endtask

  task automatic test_reset_mid();
    int we_cnt = 0;
    for (int p = 0; p < 30; p++) step(1'b1, p == 0, 1'b1);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = 1'b1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", bus.bram_we); end
    total++; if (got_pos() !== 6'h00) begin bad++; $display("FAIL rmid_pos got=%h want=00", got_pos()); end
    total++; if (bus.bram_din !== 1'b0) begin bad++; $display("FAIL rmid_din got=%b want=0", bus.bram_din); end
    @(posedge clk);
    #1;
    total++; if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL rmid_we_edge got=%b want=0", bus.bram_we); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.pix_valid = 1'b0;
    for (int p = 0; p < 64; p++) begin
      step(1'b1, 1'b0, 1'b1);
      if (bus.bram_we !== 1'b0) we_cnt++;
    end
    total++; if (we_cnt != 0) begin bad++; $display("FAIL rmid_nosof_writes got=%0d want=0", we_cnt); end
    step(1'b1, 1'b1, 1'b1);
    total++; if (bus.bram_we !== 1'b1) begin bad++; $display("FAIL rmid_sof_we got=%b want=1", bus.bram_we); end
    total++; if (got_pos() !== 6'h00) begin bad++; $display("FAIL rmid_sof_pos got=%h want=00", got_pos()); end
    total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL rmid_sof_se got=%b want=0", bus.sync_err); end
    step(1'b1, 1'b0, 1'b0);
    total++; if (got_pos() !== ex_pos(1)) begin bad++; $display("FAIL rmid_p1 got=%h want=%h", got_pos(), ex_pos(1)); end
    for (int p = 2; p < 64; p++) step(1'b1, 1'b0, ex_d(p));
    total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL rmid_end_fd got=%b want=1", bus.frame_done); end
  endtask

  task automatic test_back_to_back();
    int fd_cnt = 0;
    int p;
    for (int i = 0; i < 128; i++) begin
      p = i % 64;
      step(1'b1, p == 0, ex_d(p));
      if (bus.frame_done === 1'b1) fd_cnt++;
      total++; if (bus.bram_we !== 1'b1) begin bad++; $display("FAIL b2b_we i=%0d got=%b want=1", i, bus.bram_we); end
      total++; if (got_pos() !== ex_pos(p)) begin bad++; $display("FAIL b2b_pos i=%0d got=%h want=%h", i, got_pos(), ex_pos(p)); end
      total++; if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL b2b_se i=%0d got=%b want=0", i, bus.sync_err); end
      total++; if (bus.frame_done !== (p == 63)) begin bad++; $display("FAIL b2b_fd i=%0d got=%b", i, bus.frame_done); end
    end
    total++; if (fd_cnt != 2) begin bad++; $display("FAIL b2b_fd_count got=%0d want=2", fd_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_no_sof();
    test_gapped();
    test_mid_sof();
    test_sof_on_last();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
